// File: rtl/mesh_term_injector.sv
// mesh_term_injector: formats host transactions into mesh packets and queues them toward one mesh terminal port
module mesh_term_injector #(
  parameter int pckg_sz = 41,
  parameter int fifo_depth = 8,
  parameter int ROWS = 4,
  parameter int COLUMS = 4,
  parameter logic [7:0] bdcst = 8'hFF,
  parameter int GAP = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  logic [3:0] dst_row,
  input  logic [3:0] dst_col,
  input  logic mode,
  input  logic bcst,
  input  logic [pckg_sz-18:0] payload,
  input  logic popin,
  output logic pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic [$clog2(fifo_depth+1)-1:0] count,
  output logic full,
  output logic overflow,
  output logic bad_dst,
  output logic pop_err,
  output logic [15:0] sent_cnt
);
  localparam int pw = $clog2(fifo_depth);
  localparam int cw = $clog2(fifo_depth+1);
  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [pw-1:0] wr_ptr, rd_ptr;
  logic [3:0] gap_cnt;
  logic [7:0] dst;
  logic in_rng, pop, push;
  function automatic logic [pw-1:0] inc(input logic [pw-1:0] p);
    return p == pw'(fifo_depth-1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    dst = bcst ? bdcst : {dst_row, dst_col};
    in_rng = bcst || (32'(dst_row) <= ROWS + 1 && 32'(dst_col) <= COLUMS + 1);
    pndng_i_in = count != '0 && gap_cnt == '0;
    full = count == cw'(fifo_depth);
    pop = popin && pndng_i_in;
    push = wr_en && in_rng && (!full || pop);
    data_out_i_in = count != '0 ? mem[rd_ptr] : '0;
  end
  always_ff @(posedge clk)
    if (push && !reset) mem[wr_ptr] <= {8'h00, dst, mode, payload};
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      gap_cnt <= '0;
      overflow <= 1'b0;
      bad_dst <= 1'b0;
      pop_err <= 1'b0;
      sent_cnt <= '0;
    end else begin
      wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
      count <= count + cw'(push) - cw'(pop);
      gap_cnt <= pop ? 4'(GAP) : gap_cnt - 4'(gap_cnt != '0);
      overflow <= overflow | (wr_en && in_rng && full && !pop);
      bad_dst <= bad_dst | (wr_en && !in_rng);
      pop_err <= pop_err | (popin && !pndng_i_in);
      sent_cnt <= sent_cnt + 16'(pop && sent_cnt != '1);
    end
endmodule

// File: tb/tb_mesh_term_injector.sv
// tb_mesh_term_injector: scoreboard bench comparing the injector against a queue-based reference model
module tb_mesh_term_injector;
  localparam int W = 41, D = 8, G = 3, R = 4, C = 4, PW = W - 17;
  logic clk = 0, reset = 1, wr_en = 0, mode = 0, bcst = 0, popin = 0;
  logic [3:0] dst_row = 0, dst_col = 0;
  logic [PW-1:0] payload = '0;
  logic pndng_i_in, full, overflow, bad_dst, pop_err;
  logic [W-1:0] data_out_i_in;
  logic [3:0] count;
  logic [15:0] sent_cnt;
  logic [W-1:0] q[$];
  int cyc = 0, last_pop = -100, total = 0, bad = 0, m_sent = 0;
  bit m_ovf = 0, m_bad = 0, m_perr = 0;
  mesh_term_injector #(.pckg_sz(W), .fifo_depth(D), .ROWS(R), .COLUMS(C), .bdcst(8'hFF), .GAP(G)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .dst_row(dst_row), .dst_col(dst_col),
    .mode(mode), .bcst(bcst), .payload(payload), .popin(popin), .pndng_i_in(pndng_i_in),
    .data_out_i_in(data_out_i_in), .count(count), .full(full), .overflow(overflow),
    .bad_dst(bad_dst), .pop_err(pop_err), .sent_cnt(sent_cnt)
  );
  always #5 clk = ~clk;
  function automatic bit exp_pn();
    return q.size() != 0 && cyc - last_pop > G;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk) begin
    bit p, ok;
    p = exp_pn();
    ok = bcst || (dst_row <= R + 1 && dst_col <= C + 1);
    if (reset) begin
      q.delete();
      last_pop = -100;
      m_ovf = 0;
      m_bad = 0;
      m_perr = 0;
      m_sent = 0;
    end else begin
      if (popin && !p) m_perr = 1;
      if (wr_en && !ok) m_bad = 1;
      if (wr_en && ok && q.size() == D && !(popin && p)) m_ovf = 1;
      if (popin && p) begin
        void'(q.pop_front());
        last_pop = cyc;
        if (m_sent < 65535) m_sent++;
      end
      if (wr_en && ok && q.size() < D) q.push_back({8'h00, bcst ? 8'hFF : {dst_row, dst_col}, mode, payload});
    end
    cyc++;
  end
  always @(negedge clk)
    if (cyc > 0) begin
      chk("count", count, q.size());
      chk("full", full, q.size() == D);
      chk("pndng", pndng_i_in, exp_pn());
      chk("overflow", overflow, m_ovf);
      chk("bad_dst", bad_dst, m_bad);
      chk("pop_err", pop_err, m_perr);
      chk("sent_cnt", sent_cnt, m_sent);
      chk("head", data_out_i_in, q.size() != 0 ? q[0] : '0);
      if (pndng_i_in && popin && !reset) begin
        if (q.size() == 0) chk("pop_empty", pndng_i_in, 0);
        else chk("pop_data", data_out_i_in, q[0]);
      end
    end
  task automatic step(input bit w, input bit p, input logic [3:0] r, input logic [3:0] c, input bit m, input bit b, input logic [PW-1:0] pl);
    wr_en = w;
    popin = p;
    dst_row = r;
    dst_col = c;
    mode = m;
    bcst = b;
    payload = pl;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0);
  endtask
  task automatic push_rnd();
    step(1, 0, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 1'($urandom), 0, PW'($urandom));
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) step(0, 1, 0, 0, 0, 0, '0);
    chk("drain_timeout", q.size(), 0);
    idle(G + 1);
  endtask
  task automatic do_reset();
    reset = 1;
    idle(1);
    reset = 0;
  endtask
  initial begin
    idle(2);
    reset = 0;
    step(1, 0, 1, 2, 0, 0, 24'hABCDEF);
    chk("t1_pkt", data_out_i_in, 41'h24ABCDEF);
    idle(1);
    step(0, 1, 0, 0, 0, 0, '0);
    chk("t1_sent", sent_cnt, 1);
    idle(G + 1);
    do_reset();
    repeat (9) push_rnd();
    chk("t2_full", full, 1);
    drain();
    do_reset();
    repeat (4) push_rnd();
    drain();
    do_reset();
    step(1, 0, 9, 9, 0, 1, PW'($urandom));
    chk("t4_bcst_rc", data_out_i_in[32:25], 8'hFF);
    step(1, 0, 6, 0, 0, 0, PW'($urandom));
    chk("t4_count", count, 1);
    drain();
    do_reset();
    repeat (8) push_rnd();
    step(1, 1, 3, 3, 1, 0, PW'($urandom));
    chk("t5_count", count, 8);
    drain();
    do_reset();
    repeat (3) push_rnd();
    drain();
    repeat (5) push_rnd();
    reset = 1;
    step(1, 0, 1, 1, 0, 0, PW'($urandom));
    reset = 0;
    chk("t6_sent", sent_cnt, 0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
           1'($urandom), $urandom_range(0, 15) == 0, PW'($urandom));
    end
    reset = 0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
